// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receiver control path.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    RECV     = 3'd2,
    STOP_CHK = 3'd3,
    ERR_CHK  = 3'd4,
    LOAD     = 3'd5
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/rx_control_unit_if.sv
// Signal bundle between the receive controller and its surrounding receiver blocks.
interface rx_control_unit_if;

  logic serial_in;
  logic packet_done;
  logic stop_bit;
  logic enable_timer;
  logic start_detected;
  logic framing_error;
  logic load_buffer;

  modport master (
    output serial_in, packet_done, stop_bit,
    input  enable_timer, start_detected, framing_error, load_buffer
  );

  modport slave (
    input  serial_in, packet_done, stop_bit,
    output enable_timer, start_detected, framing_error, load_buffer
  );

endinterface

// File: rtl/rx_control_unit_start_bit_det.sv
// Serial line synchronizer with a one-cycle pulse on each synchronized falling edge.
module start_bit_det
  import rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_serial,
  output logic o_start
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync_out;

  // Flops reset to the idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= {SYNC_STAGES{LINE_IDLE}};
      r_prev <= LINE_IDLE;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_serial};
      r_prev <= w_sync_out;
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign o_start    = r_prev & ~w_sync_out;

endmodule

// File: rtl/rx_control_unit.sv
// Receive control FSM: start detection, bit-timer gating, stop-bit check and buffer load.
module rx_control_unit
  import rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  rx_control_unit_if.slave   bus
);

  rx_state_t r_state;
  rx_state_t w_next;
  logic      r_framing_error;
  logic      w_start;

  start_bit_det #(.SYNC_STAGES(SYNC_STAGES)) u_start_bit_det (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_serial (bus.serial_in),
    .o_start  (w_start)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_start) w_next = CLR;
      CLR:      w_next = RECV;
      RECV:     if (bus.packet_done) w_next = STOP_CHK;
      STOP_CHK: w_next = ERR_CHK;
      // A bad stop bit discards the packet rather than loading it.
      ERR_CHK:  w_next = r_framing_error ? IDLE : LOAD;
      LOAD:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.enable_timer = (r_state == RECV);
    bus.load_buffer  = (r_state == LOAD);
  end

  // Sticky until the next packet clears it, so software can read it while idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                     r_framing_error <= 1'b0;
    else if (r_state == CLR)        r_framing_error <= 1'b0;
    else if (r_state == STOP_CHK)   r_framing_error <= ~bus.stop_bit;
  end

  assign bus.framing_error  = r_framing_error;
  assign bus.start_detected = w_start;

endmodule

// File: doc/rx_control_unit.md
Name: rx_control_unit

Overview:
Receive-side control block for the serial receiver. It synchronizes the raw serial line and detects the start-bit falling edge. It sequences a packet by driving enable_timer into the bit-timing block and consuming that block's packet_done pulse. It then checks the stop bit, flags framing errors, and issues a one-cycle load strobe to the receive data buffer.

Parameters:
SYNC_STAGES, 2, number of metastability flops on serial_in (legal range 2..4)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous, active-low reset
serial_in  input  1  raw serial line (asynchronous to clk); idles high
packet_done  input  1  one-cycle pulse from the bit timer after the final bit sample of a packet
stop_bit  input  1  stop-bit value currently held by the receive shift register
enable_timer  output  1  high while a packet is being sampled; gates the bit timer
start_detected  output  1  one-cycle pulse on a synchronized 1->0 transition of the line
framing_error  output  1  sticky flag: the last packet's stop bit was 0
load_buffer  output  1  one-cycle strobe: the shift-register contents are valid, load them into the receive buffer

Behaviour:
- Reset (async, n_rst=0): all sync flops and the previous-value flop = 1 (idle line); state = IDLE; enable_timer=0, start_detected=0, framing_error=0, load_buffer=0. Reset asserted mid-packet aborts the packet immediately; no load_buffer is issued.
- Synchronizer: SYNC_STAGES-deep flop chain; its last stage is sync_out. prev = sync_out delayed one clock.
- start_detected = prev & ~sync_out (combinational from flops).
  - With SYNC_STAGES=2, a line fall first captured at edge k gives start_detected high during the cycle following edge k+1, for exactly one cycle.
  - It is an unconditional pulse, generated in every state.
- FSM states: IDLE, CLR, RECV, STOP_CHK, ERR_CHK, LOAD. All outputs except start_detected and framing_error are Moore-decoded from state.
  - IDLE: all strobes 0. If start_detected=1 -> CLR; otherwise stay in IDLE. start_detected in any other state is ignored.
  - CLR (1 cycle): framing_error <= 0. -> RECV.
  - RECV: enable_timer=1. If packet_done=1 -> STOP_CHK; otherwise stay in RECV. packet_done outside RECV is ignored.
  - STOP_CHK (1 cycle): enable_timer=0; framing_error <= ~stop_bit. -> ERR_CHK.
  - ERR_CHK (1 cycle): if framing_error=1 -> IDLE (no load); else -> LOAD.
  - LOAD (1 cycle): load_buffer=1. -> IDLE.
- Latency:
  - packet_done accepted in RECV -> load_buffer high 3 cycles later (STOP_CHK, ERR_CHK, LOAD).
  - start_detected -> enable_timer high 2 cycles later (CLR, then RECV).
- framing_error holds its value through IDLE. It is cleared only in CLR of the next packet, or by reset.
- A line glitch shorter than one clock may be missed. A glitch that is captured is treated as a start bit. Glitch filtering is out of scope.
- enable_timer is never high outside RECV.
- Back-to-back packets: a start edge arriving in STOP_CHK, ERR_CHK or LOAD is dropped. The line must be seen high in IDLE and then fall again.

Decomposition:
- Package rx_pkg holds:
  - typedef enum rx_state_t {IDLE, CLR, RECV, STOP_CHK, ERR_CHK, LOAD} (3-bit);
  - constant LINE_IDLE = 1'b1.
- Sub-module start_bit_det: synchronizer, prev flop and edge pulse, parameterized by SYNC_STAGES. rx_control_unit instantiates it and holds the FSM and the framing_error register.

Test Plan:
1. Reset check: hold n_rst=0 with serial_in=0 -> all outputs 0, no start_detected. Release reset with line high -> outputs stay 0.
2. Good packet: drop serial_in at edge 10. Model the timer as 9 strobes of 10 clocks each, with packet_done pulsed in RECV and stop_bit=1 -> start_detected at cycle 11, enable_timer from cycle 13 until packet_done, load_buffer exactly 1 cycle, 3 cycles after packet_done; framing_error=0.
3. Framing error: same as test 2 with stop_bit=0 -> framing_error=1 from ERR_CHK onward, no load_buffer, return to IDLE. The next start edge clears framing_error in CLR.
4. Ignored events: toggle serial_in high/low during RECV, and pulse packet_done while in IDLE -> no extra start_detected-driven transitions, no enable_timer, no load_buffer.
5. Mid-packet reset: assert n_rst for 1 cycle while in RECV -> enable_timer drops asynchronously, state IDLE, no load_buffer. The next start edge behaves as in test 2.
6. SYNC_STAGES=3: repeat test 2 -> start_detected, enable_timer and load_buffer each shifted one cycle later, with no other change.
